// File: rtl/router_pkt_gen_if.sv
// Bundle between the router packet generator and the router: request side
// (start, destination, length, seed, error request, back-pressure) and beat side.
interface router_pkt_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;

  logic                  start;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic [LEN_WIDTH-1:0]  payload_len;
  logic [15:0]           seed;
  logic                  corrupt_parity;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  pkt_valid;
  logic                  active;
  logic                  done;
  logic                  reject;
  logic [15:0]           pkt_count;

  modport master (
    input  start, dest_addr, payload_len, seed, corrupt_parity, busy,
    output data_out, pkt_valid, active, done, reject, pkt_count
  );

  modport slave (
    output start, dest_addr, payload_len, seed, corrupt_parity, busy,
    input  data_out, pkt_valid, active, done, reject, pkt_count
  );
endinterface

// File: rtl/router_pkt_gen.sv
// Router packet generator: header, LFSR payload and parity beat per request.
// Optional error injection on the parity beat: define ROUTER_PKT_GEN_ERR_INJ_EN.
module router_pkt_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_CHAN   = 3
) (
  input  logic             clock,
  input  logic             reset,
  router_pkt_gen_if.master bus
);
  localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CHAN_LIMIT   = (ADDR_WIDTH+1)'(NUM_CHAN);
  localparam logic [15:0]         LFSR_DEFAULT = 16'hACE1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE     = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } state_t;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced
  function automatic logic [15:0] lfsr_load(input logic [15:0] raw);
    return (raw == 16'h0000) ? LFSR_DEFAULT : raw;
  endfunction

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] data_r, data_s;
  logic                  valid_r, valid_s;
  logic                  active_r, active_s;
  logic                  done_r, done_s;
  logic                  reject_r, reject_s;
  logic [15:0]           count_r, count_s;
  logic [15:0]           lfsr_r, lfsr_s;
  logic [DATA_WIDTH-1:0] par_r, par_s;
  logic [LEN_WIDTH-1:0]  rem_r, rem_s;
  logic                  inj_r, inj_s;
  logic                  start_ok_s;
  logic                  inj_req_s;
  logic [DATA_WIDTH-1:0] header_s;
  logic [DATA_WIDTH-1:0] inj_mask_s;

`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  assign inj_req_s = bus.corrupt_parity;
`else
  // Port kept so both builds share one interface; its value has no effect here
  logic unused_corrupt_s;
  assign unused_corrupt_s = bus.corrupt_parity;
  assign inj_req_s        = 1'b0;
`endif

  assign start_ok_s = (bus.payload_len != {LEN_WIDTH{1'b0}}) &&
                      ({1'b0, bus.dest_addr} < CHAN_LIMIT);
  assign header_s   = {bus.payload_len, bus.dest_addr};
  assign inj_mask_s = {{(DATA_WIDTH-1){1'b0}}, inj_r};

  // Next-state and next-output logic; rem counts payload beats still to emit
  always_comb begin
    state_s  = state_r;
    data_s   = data_r;
    valid_s  = valid_r;
    active_s = active_r;
    done_s   = 1'b0;
    reject_s = 1'b0;
    count_s  = count_r;
    lfsr_s   = lfsr_r;
    par_s    = par_r;
    rem_s    = rem_r;
    inj_s    = inj_r;
    case (state_r)
      IDLE: begin
        data_s   = {DATA_WIDTH{1'b0}};
        valid_s  = 1'b0;
        active_s = 1'b0;
        if (bus.start && start_ok_s) begin
          state_s  = HEADER;
          data_s   = header_s;
          valid_s  = 1'b1;
          active_s = 1'b1;
          par_s    = header_s;
          lfsr_s   = lfsr_load(bus.seed);
          rem_s    = bus.payload_len;
          inj_s    = inj_req_s;
        end else if (bus.start) begin
          reject_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      HEADER: begin
        if (!bus.busy) begin
          state_s = PAYLOAD;
          data_s  = lfsr_r[DATA_WIDTH-1:0];
          lfsr_s  = lfsr_step(lfsr_r);
          rem_s   = rem_r - LEN_ONE;
        end else begin
          state_s = HEADER;
        end
      end
      PAYLOAD: begin
        if (!bus.busy) begin
          par_s = par_r ^ data_r;
          // The beat being accepted is the last one: fold it and present parity
          if (rem_r == {LEN_WIDTH{1'b0}}) begin
            state_s = PARITY;
            valid_s = 1'b0;
            data_s  = par_r ^ data_r ^ inj_mask_s;
          end else begin
            data_s = lfsr_r[DATA_WIDTH-1:0];
            lfsr_s = lfsr_step(lfsr_r);
            rem_s  = rem_r - LEN_ONE;
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          state_s  = IDLE;
          data_s   = {DATA_WIDTH{1'b0}};
          valid_s  = 1'b0;
          active_s = 1'b0;
          done_s   = 1'b1;
          count_s  = count_r + 16'd1;
        end else begin
          state_s = PARITY;
        end
      end
      default: begin
        state_s  = IDLE;
        data_s   = {DATA_WIDTH{1'b0}};
        valid_s  = 1'b0;
        active_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset aborts any packet
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      data_r   <= {DATA_WIDTH{1'b0}};
      valid_r  <= 1'b0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
      reject_r <= 1'b0;
      count_r  <= 16'd0;
      lfsr_r   <= LFSR_DEFAULT;
      par_r    <= {DATA_WIDTH{1'b0}};
      rem_r    <= {LEN_WIDTH{1'b0}};
      inj_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      data_r   <= data_s;
      valid_r  <= valid_s;
      active_r <= active_s;
      done_r   <= done_s;
      reject_r <= reject_s;
      count_r  <= count_s;
      lfsr_r   <= lfsr_s;
      par_r    <= par_s;
      rem_r    <= rem_s;
      inj_r    <= inj_s;
    end
  end

  assign bus.data_out  = data_r;
  assign bus.pkt_valid = valid_r;
  assign bus.active    = active_r;
  assign bus.done      = done_r;
  assign bus.reject    = reject_r;
  assign bus.pkt_count = count_r;
endmodule
